// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; start bit, DATA_W bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          overflow,
    output logic                          TX,
    output logic                          busy,
    output logic                          tx_done
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = 4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                ovf_q;

    logic                push;
    logic                pop;
    logic                bit_end;
    logic                fifo_empty;

    assign fifo_empty = (cnt_q == '0);
    assign bit_end    = (baud_q == BAUD_W'(BAUD_DIV - 1));
    // A write seen while full is dropped even if a pop frees a slot on the same edge.
    assign push       = wr_en && !full_q;
    assign cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign full_d     = (cnt_d == CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q  <= cnt_d;
            full_q <= full_d;
            ovf_q  <= wr_en && full_q;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = done_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        done_d  = 1'b1;
                        bit_d   = '0;
                        state_d = IDLE;
                        pop     = !fifo_empty;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Starting a frame overrides the end-of-frame update so back-to-back frames
        // leave no idle clock and tx_done stays low across the seam.
        if (pop) begin
            state_d = START;
            shift_d = mem_q[rd_ptr_q];
            baud_d  = '0;
            bit_d   = '0;
            done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rd_ptr_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        TX = 1'b1;
        unique case (state_q)
            IDLE:   TX = 1'b1;
            START:  TX = 1'b0;
            DATA:   TX = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: TX = par_q;
`endif
            STOP:   TX = 1'b1;
            default: TX = 1'b1;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign tx_done  = done_q;
    assign full     = full_q;
    assign fifo_cnt = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model (queue of bytes plus a queue of
// expected per-clock line levels) compared against the DUT after every clock edge.
module tb_uart_tx_fifo;

    localparam int BAUD  = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS  = 11;
    localparam int FRAME2_BITS = 9;
`else
    localparam int FRAME_BITS  = 10;
    localparam int FRAME2_BITS = 8;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic [2:0] fifo_cnt;
    logic       overflow;
    logic       TX;
    logic       busy;
    logic       tx_done;

    logic       wr_en2;
    logic [4:0] wr_data2;
    logic       full2;
    logic [1:0] fifo_cnt2;
    logic       overflow2;
    logic       TX2;
    logic       busy2;
    logic       tx_done2;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    bit         line[$];
    logic       m_done;
    logic       m_ovf;

    uart_tx_fifo #(.DATA_W(8), .BAUD_DIV(BAUD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .fifo_cnt(fifo_cnt), .overflow(overflow),
        .TX(TX), .busy(busy), .tx_done(tx_done)
    );

    uart_tx_fifo #(.DATA_W(5), .BAUD_DIV(BAUD), .STOP_BITS(2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data2),
        .full(full2), .fifo_cnt(fifo_cnt2), .overflow(overflow2),
        .TX(TX2), .busy(busy2), .tx_done(tx_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        line.delete();
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] d);
        for (int s = 0; s < FRAME_BITS; s++) begin
            bit b;
            if (s == 0) b = 1'b0;
            else if (s <= 8) b = d[s-1];
`ifdef UART_TX_PARITY_EN
            else if (s == 9) b = ^d;
`endif
            else b = 1'b1;
            repeat (BAUD) line.push_back(b);
        end
    endtask

    task automatic check_all();
        chk("tx",       32'(TX),       32'(line.size() > 0 ? line[0] : 1'b1));
        chk("busy",     32'(busy),     32'(line.size() > 0));
        chk("tx_done",  32'(tx_done),  32'(m_done));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        chk("full",     32'(full),     32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic tick(input logic we, input logic [7:0] d);
        logic acc;
        logic ended;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            acc   = we && (mq.size() < DEPTH);
            m_ovf = we && !acc;
            ended = 1'b0;
            if (line.size() > 0) begin
                void'(line.pop_front());
                ended = (line.size() == 0);
            end
            if (line.size() == 0 && mq.size() > 0) begin
                start_frame(mq.pop_front());
                m_done = 1'b0;
            end else if (ended) begin
                m_done = 1'b1;
            end
            if (acc) mq.push_back(d);
        end
        #1;
        check_all();
    endtask

    task automatic drain(output int nbusy);
        int n;
        n = 0;
        nbusy = 0;
        while ((line.size() > 0 || mq.size() > 0) && n < 6000) begin
            tick(1'b0, 8'h00);
            n++;
            if (busy) nbusy++;
        end
        tick(1'b0, 8'h00);
        chk("drain_bound", 32'(n < 6000), 32'd1);
    endtask

    task automatic run_frame(input logic [7:0] d, output logic [11:0] v, output int len);
        v   = '0;
        len = 0;
        tick(1'b1, d);
        for (int k = 0; k < 400; k++) begin
            tick(1'b0, 8'h00);
            if (!busy) break;
            if ((k % BAUD) == BAUD / 2 && (k / BAUD) < 12) v[k / BAUD] = TX;
            len++;
        end
    endtask

    initial begin
        int          nb;
        int          ov;
        logic [11:0] v;
        int          len;
        bit          e2;
        int          slot;

        rst_n    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        wr_en2   = 1'b0;
        wr_data2 = '0;
        model_clear();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tx",       32'(TX),        32'd1);
        chk("rst_busy",     32'(busy),      32'd0);
        chk("rst_done",     32'(tx_done),   32'd0);
        chk("rst_cnt",      32'(fifo_cnt),  32'd0);
        chk("rst_full",     32'(full),      32'd0);
        chk("rst_ovf",      32'(overflow),  32'd0);
        chk("rst_tx2",      32'(TX2),       32'd1);
        chk("rst_cnt2",     32'(fifo_cnt2), 32'd0);
        chk("rst_full2",    32'(full2),     32'd0);
        chk("rst_ovf2",     32'(overflow2), 32'd0);
        repeat (2) tick(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (3) tick(1'b0, 8'h00);

        // Single frame and exact bit pattern / timing.
        run_frame(8'hA5, v, len);
`ifndef UART_TX_PARITY_EN
        chk("a5_bits", 32'(v[9:0]), 32'h34A);
`endif
        chk("a5_len",  32'(len),     32'(FRAME_BITS * BAUD));
        chk("a5_done", 32'(tx_done), 32'd1);
        chk("a5_busy", 32'(busy),    32'd0);
`ifdef UART_TX_PARITY_EN
        run_frame(8'h07, v, len);
        chk("par07_bit", 32'(v[9]), 32'd1);
        chk("par07_len", 32'(len),  32'd176);
        run_frame(8'h03, v, len);
        chk("par03_bit", 32'(v[9]), 32'd0);
        chk("par03_len", 32'(len),  32'd176);
`endif

        // Burst of three back-to-back frames.
        tick(1'b1, 8'h00); chk("burst_cnt0", 32'(fifo_cnt), 32'd1);
        tick(1'b1, 8'hFF); chk("burst_cnt1", 32'(fifo_cnt), 32'd1);
        tick(1'b1, 8'h3C); chk("burst_cnt2", 32'(fifo_cnt), 32'd2);
        drain(nb);
        chk("burst_len", 32'(nb + 2), 32'(3 * FRAME_BITS * BAUD));

        // Six writes into a 4-deep FIFO while the first frame starts.
        ov = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'h40 + i));
            if (overflow) ov++;
        end
        chk("ovf_cnt",  32'(fifo_cnt), 32'd4);
        chk("ovf_full", 32'(full),     32'd1);
        tick(1'b0, 8'h00);
        if (overflow) ov++;
        chk("ovf_pulses", 32'(ov), 32'd1);
        drain(nb);
        chk("ovf_len", 32'(nb + 6), 32'(5 * FRAME_BITS * BAUD));

        // Randomized writes against the reference model.
        for (int i = 0; i < 1500; i++) begin
            tick(($urandom_range(0, 23) == 0), 8'($urandom));
        end
        drain(nb);

        // Second instance: 5 data bits, 2 stop bits.
        wr_en2   = 1'b1;
        wr_data2 = 5'h15;
        tick(1'b0, 8'h00);
        wr_en2   = 1'b0;
        wr_data2 = 5'h0A;
        for (int k = 0; k < FRAME2_BITS * BAUD; k++) begin
            tick(1'b0, 8'h00);
            slot = k / BAUD;
            if (slot == 0) e2 = 1'b0;
            else if (slot <= 5) e2 = ((32'h15 >> (slot - 1)) & 1) != 0;
`ifdef UART_TX_PARITY_EN
            else if (slot == 6) e2 = 1'b1;
`endif
            else e2 = 1'b1;
            chk("d2_tx",   32'(TX2),   32'(e2));
            chk("d2_busy", 32'(busy2), 32'd1);
        end
        tick(1'b0, 8'h00);
        chk("d2_end_tx",   32'(TX2),       32'd1);
        chk("d2_end_busy", 32'(busy2),     32'd0);
        chk("d2_end_done", 32'(tx_done2),  32'd1);
        chk("d2_end_cnt",  32'(fifo_cnt2), 32'd0);

        // Reset in the middle of a frame with two entries queued.
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        tick(1'b1, 8'h33);
        repeat (48) tick(1'b0, 8'h00);
        chk("mid_cnt", 32'(fifo_cnt), 32'd2);
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_tx",   32'(TX),       32'd1);
        chk("mid_rst_cnt",  32'(fifo_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy),     32'd0);
        chk("mid_rst_done", 32'(tx_done),  32'd0);
        chk("mid_rst_full", 32'(full),     32'd0);
        repeat (3) tick(1'b0, 8'h00);
        rst_n = 1'b1;
        repeat (300) tick(1'b0, 8'h00);
        chk("post_rst_busy", 32'(busy),     32'd0);
        chk("post_rst_cnt",  32'(fifo_cnt), 32'd0);
        run_frame(8'h5A, v, len);
        chk("post_rst_len", 32'(len), 32'(FRAME_BITS * BAUD));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter BAUD_DIV, default 2604, clocks per bit period, legal range 4..65535.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-004 Parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, 2..16.
REQ-005 Port clk, input, 1: system clock, all logic on rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port wr_en, input, 1: push wr_data into the FIFO this cycle.
REQ-008 Port wr_data, input, DATA_W: byte to enqueue.
REQ-009 Port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-010 Port fifo_cnt, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-011 Port overflow, output, 1: one-cycle pulse when a write is dropped.
REQ-012 Port TX, output, 1: serial line, idle high.
REQ-013 Port busy, output, 1: high while a frame is on the line.
REQ-014 Port tx_done, output, 1: sticky frame-complete flag.

Function
REQ-015 Frame order SHALL be: start bit (0), DATA_W data bits LSB first, optional parity bit (REQ-029), STOP_BITS stop bits (1).
REQ-016 Every bit SHALL last exactly BAUD_DIV clocks, timed by a baud counter that counts 0..BAUD_DIV-1 and wraps.
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
  - IDLE->START when the FIFO is non-empty.
  - START->DATA after 1 bit period.
  - DATA->PARITY (macro on) or STOP after DATA_W bit periods.
  - PARITY->STOP after 1 bit period.
  - STOP->START if the FIFO is non-empty at the end of the final stop bit, else STOP->IDLE.
REQ-018 On a clock edge where the FSM is in IDLE and the FIFO is non-empty, the FSM SHALL pop one entry and drive TX low from that edge on.
  - Latency: wr_en into an empty FIFO in IDLE at edge N puts the start bit on TX after edge N+1.
REQ-019 Back-to-back frames SHALL have zero idle clocks between the last stop bit and the next start bit.
REQ-020 A write with full=1 SHALL be dropped and SHALL pulse overflow for one cycle; FIFO contents are unchanged.
  - This holds even if a pop occurs on the same edge.
REQ-021 A simultaneous write and pop with full=0 SHALL leave fifo_cnt unchanged and preserve FIFO order.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 full and fifo_cnt SHALL be registered and valid the cycle after the write or pop.
REQ-024 busy SHALL be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-025 tx_done SHALL set at the end of the final stop bit of each frame and SHALL clear on the edge a new frame starts.
REQ-026 wr_data SHALL be captured at the write edge; later changes to wr_data SHALL not affect queued frames.

Reset
REQ-027 rst_n low SHALL immediately force the following, regardless of frame in progress:
  - TX=1, busy=0, tx_done=0, overflow=0;
  - FIFO emptied: fifo_cnt=0, full=0;
  - FSM to IDLE; baud and bit counters to 0.
REQ-028 The first edge after rst_n deasserts SHALL behave as IDLE with an empty FIFO.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the DATA_W data bits) SHALL be sent after the data bits, making the frame 2+DATA_W+STOP_BITS bits long.
REQ-030 Macro UART_TX_PARITY_EN undefined: no PARITY state and no parity logic SHALL exist, and the frame SHALL be 1+DATA_W+STOP_BITS bits long.

Verification
REQ-031 Single frame (DATA_W=8, BAUD_DIV=16, STOP_BITS=1, no parity): write 0xA5 -> TX samples 0,1,0,1,0,0,1,0,1,1, each held 16 clocks; tx_done rises 160 clocks after the start bit; busy=0 afterwards.
REQ-032 Burst: write 0x00, 0xFF, 0x3C on 3 consecutive cycles -> three contiguous 160-clock frames with zero idle clocks between them; fifo_cnt sequence observed.
REQ-033 Overflow (FIFO_DEPTH=4): 6 consecutive writes while the first frame starts -> exactly one overflow pulse and 5 frames transmitted, all in write order.
REQ-034 Parity (macro on): write 0x07 -> parity bit 1 at bit slot 9; write 0x03 -> parity bit 0; each frame is 11 bits = 176 clocks.
REQ-035 Reset mid-frame: assert rst_n at clock 50 of a frame with 2 entries queued -> TX=1 asynchronously, fifo_cnt=0; no further frames after release until a new write.
REQ-036 STOP_BITS=2, DATA_W=5: write 0x15 -> TX high for 32 clocks after the 5 data bits; total frame 128 clocks.
